// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: hazard/redirect inputs, instruction-memory port and IF/ID outputs.
// The master side is the fetch unit; the slave side is the surrounding pipeline/memory.
interface fetch_unit_if #(
    parameter int PC_LENGTH   = 32,
    parameter int INST_LENGTH = 32
);
    logic                   stall;
    logic                   redirect_valid;
    logic [PC_LENGTH-1:0]   redirect_pc;
    logic [PC_LENGTH-1:0]   imem_pc;
    logic [INST_LENGTH-1:0] imem_inst;
    logic [PC_LENGTH-1:0]   if_pc;
    logic [INST_LENGTH-1:0] if_inst;
    logic                   if_valid;
    logic                   misalign_err;
    logic [31:0]            fetch_count;

    modport master (
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        input  imem_inst,
        output imem_pc,
        output if_pc,
        output if_inst,
        output if_valid,
        output misalign_err,
        output fetch_count
    );

    modport slave (
        output stall,
        output redirect_valid,
        output redirect_pc,
        output imem_inst,
        input  imem_pc,
        input  if_pc,
        input  if_inst,
        input  if_valid,
        input  misalign_err,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: owns the PC, fills the IF/ID register, handles stall and redirect.
// IF_MISALIGN_TRAP_EN: a misaligned redirect halts fetch and raises misalign_err until reset.
module fetch_unit #(
    parameter int                   PC_LENGTH   = 32,
    parameter int                   INST_LENGTH = 32,
    parameter logic [PC_LENGTH-1:0] RESET_PC    = 32'h0000_0000,
    parameter logic [INST_LENGTH-1:0] NOP_INST  = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_unit_if.master    bus
);

`ifdef IF_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic [PC_LENGTH-1:0]   pc_q, pc_d;
    logic [PC_LENGTH-1:0]   if_pc_q, if_pc_d;
    logic [INST_LENGTH-1:0] if_inst_q, if_inst_d;
    logic                   if_valid_q, if_valid_d;
    logic [31:0]            fetch_count_q, fetch_count_d;

    logic [PC_LENGTH-1:0]   redirect_aligned;

    // Targets are always word-aligned before use; the low bits only matter for the trap.
    assign redirect_aligned = {bus.redirect_pc[PC_LENGTH-1:2], 2'b00};

`ifdef IF_MISALIGN_TRAP_EN
    logic redirect_misaligned;
    assign redirect_misaligned = |bus.redirect_pc[1:0];
`else
    logic redirect_lsb_unused;
    assign redirect_lsb_unused = ^bus.redirect_pc[1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            if_pc_q       <= '0;
            if_inst_q     <= NOP_INST;
            if_valid_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_pc_q       <= if_pc_d;
            if_inst_q     <= if_inst_d;
            if_valid_q    <= if_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_pc_d       = if_pc_q;
        if_inst_d     = if_inst_q;
        if_valid_d    = if_valid_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            ST_BOOT: begin
                // IF/ID still holds the reset bubble; only the PC may be redirected here.
                state_d = ST_RUN;
                if (bus.redirect_valid) begin
                    pc_d = redirect_aligned;
`ifdef IF_MISALIGN_TRAP_EN
                    if (redirect_misaligned) begin
                        state_d = ST_HALT;
                    end
`endif
                end
            end

            ST_RUN: begin
                if (bus.redirect_valid) begin
                    pc_d       = redirect_aligned;
                    if_pc_d    = '0;
                    if_inst_d  = NOP_INST;
                    if_valid_d = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
                    if (redirect_misaligned) begin
                        state_d = ST_HALT;
                    end
`endif
                end else if (!bus.stall) begin
                    if_pc_d       = pc_q;
                    if_inst_d     = bus.imem_inst;
                    if_valid_d    = 1'b1;
                    pc_d          = pc_q + PC_LENGTH'(4);
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end

`ifdef IF_MISALIGN_TRAP_EN
            ST_HALT: begin
                if_pc_d    = '0;
                if_inst_d  = NOP_INST;
                if_valid_d = 1'b0;
            end
`endif

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_comb begin
        bus.imem_pc     = pc_q;
        bus.if_pc       = if_pc_q;
        bus.if_inst     = if_inst_q;
        bus.if_valid    = if_valid_q;
        bus.fetch_count = fetch_count_q;
`ifdef IF_MISALIGN_TRAP_EN
        bus.misalign_err = (state_q == ST_HALT);
`else
        bus.misalign_err = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand sequences and a randomized
// run against a behavioural model of the fetch stage.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if #(.PC_LENGTH(32), .INST_LENGTH(32)) bus ();

    fetch_unit #(
        .PC_LENGTH  (32),
        .INST_LENGTH(32),
        .RESET_PC   (32'h0000_0000),
        .NOP_INST   (32'h0000_0013)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign bus.imem_inst = mem_word(bus.imem_pc);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: fetch stream state, not an image of the RTL registers.
    logic [31:0] m_pc, m_if_pc, m_if_inst, m_cnt;
    logic        m_valid;
    bit          m_booted, m_halt;

    task automatic model_reset();
        m_pc = 32'h0; m_if_pc = 32'h0; m_if_inst = NOP; m_valid = 1'b0;
        m_cnt = 32'h0; m_booted = 0; m_halt = 0;
    endtask

    task automatic model_edge(input logic s, input logic rv, input logic [31:0] rpc);
        if (m_halt) return;
        if (rv) begin
            m_pc = rpc & ~32'h3;
            m_if_pc = 32'h0; m_if_inst = NOP; m_valid = 1'b0;
            if (TRAP && rpc[1:0] != 2'b00) m_halt = 1;
        end else if (m_booted && !s) begin
            m_if_pc = m_pc; m_if_inst = mem_word(m_pc); m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
        end
        m_booted = 1;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".imem_pc"},  bus.imem_pc,      m_pc);
        check({tag, ".if_pc"},    bus.if_pc,        m_if_pc);
        check({tag, ".if_inst"},  bus.if_inst,      m_if_inst);
        check({tag, ".if_valid"}, 32'(bus.if_valid), 32'(m_valid));
        check({tag, ".misalign"}, 32'(bus.misalign_err), 32'(m_halt));
        check({tag, ".count"},    bus.fetch_count,  m_cnt);
    endtask

    task automatic compare_reset(input string tag);
        check({tag, ".imem_pc"},  bus.imem_pc, 32'h0);
        check({tag, ".if_pc"},    bus.if_pc, 32'h0);
        check({tag, ".if_inst"},  bus.if_inst, NOP);
        check({tag, ".if_valid"}, 32'(bus.if_valid), 32'h0);
        check({tag, ".misalign"}, 32'(bus.misalign_err), 32'h0);
        check({tag, ".count"},    bus.fetch_count, 32'h0);
    endtask

    // Called at a negedge: drive, take the posedge, sample 1 time unit later, return to negedge.
    task automatic step(input logic s, input logic rv, input logic [31:0] rpc);
        bus.stall = s; bus.redirect_valid = rv; bus.redirect_pc = rpc;
        @(posedge clk);
        model_edge(s, rv, rpc);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] e_if_pc;
        logic [31:0] e_inst;
        logic        e_valid;
        logic [31:0] e_imem;
        logic [31:0] e_cnt;
        logic        e_mis;
    } vec_t;

    vec_t tbl[14];

    task automatic set_vec(input int i, input logic s, input logic rv, input logic [31:0] rpc,
                           input logic [31:0] ip, input logic [31:0] ii, input logic iv,
                           input logic [31:0] im, input logic [31:0] c, input logic mis);
        tbl[i].stall = s; tbl[i].rv = rv; tbl[i].rpc = rpc;
        tbl[i].e_if_pc = ip; tbl[i].e_inst = ii; tbl[i].e_valid = iv;
        tbl[i].e_imem = im; tbl[i].e_cnt = c; tbl[i].e_mis = mis;
    endtask

    initial begin
        // Reset release, fetch sequence, 3-cycle stall, redirect-over-stall, wrap, misaligned target.
        set_vec(0,  0, 0, 32'h0,         32'h0,         NOP,                    0, 32'h0,   0, 0);
        set_vec(1,  0, 0, 32'h0,         32'h0,         32'h00A0_0093,          1, 32'h4,   1, 0);
        set_vec(2,  0, 0, 32'h0,         32'h4,         mem_word(32'h4),        1, 32'h8,   2, 0);
        set_vec(3,  0, 0, 32'h0,         32'h8,         mem_word(32'h8),        1, 32'hC,   3, 0);
        set_vec(4,  1, 0, 32'h0,         32'h8,         mem_word(32'h8),        1, 32'hC,   3, 0);
        set_vec(5,  1, 0, 32'h0,         32'h8,         mem_word(32'h8),        1, 32'hC,   3, 0);
        set_vec(6,  1, 0, 32'h0,         32'h8,         mem_word(32'h8),        1, 32'hC,   3, 0);
        set_vec(7,  0, 0, 32'h0,         32'hC,         mem_word(32'hC),        1, 32'h10,  4, 0);
        set_vec(8,  1, 1, 32'h100,       32'h0,         NOP,                    0, 32'h100, 4, 0);
        set_vec(9,  0, 0, 32'h0,         32'h100,       mem_word(32'h100),      1, 32'h104, 5, 0);
        set_vec(10, 0, 1, 32'hFFFF_FFFC, 32'h0,         NOP,                    0, 32'hFFFF_FFFC, 5, 0);
        set_vec(11, 0, 0, 32'h0,         32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1, 32'h0,  6, 0);
        set_vec(12, 0, 1, 32'h102,       32'h0,         NOP,                    0, 32'h100, 6, TRAP);
        if (TRAP)
            set_vec(13, 0, 0, 32'h0, 32'h0,   NOP,               0, 32'h100, 6, 1);
        else
            set_vec(13, 0, 0, 32'h0, 32'h100, mem_word(32'h100), 1, 32'h104, 7, 0);

        rst_n = 1'b0;
        bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_reset("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].stall, tbl[i].rv, tbl[i].rpc);
            check($sformatf("vec%0d.if_pc", i),    bus.if_pc, tbl[i].e_if_pc);
            check($sformatf("vec%0d.if_inst", i),  bus.if_inst, tbl[i].e_inst);
            check($sformatf("vec%0d.if_valid", i), 32'(bus.if_valid), 32'(tbl[i].e_valid));
            check($sformatf("vec%0d.imem_pc", i),  bus.imem_pc, tbl[i].e_imem);
            check($sformatf("vec%0d.count", i),    bus.fetch_count, tbl[i].e_cnt);
            check($sformatf("vec%0d.misalign", i), 32'(bus.misalign_err), 32'(tbl[i].e_mis));
            $display("[TB] vec %0d: stall=%0d rv=%0d rpc=%h -> if_pc=%h if_inst=%h v=%0d imem_pc=%h cnt=%0d",
                     i, tbl[i].stall, tbl[i].rv, tbl[i].rpc, bus.if_pc, bus.if_inst,
                     bus.if_valid, bus.imem_pc, bus.fetch_count);
            @(negedge clk);
        end

        // Ten edges after the misaligned redirect: frozen when trapping, normal fetch otherwise.
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom_range(0, 1)), 1'(i == 5), 32'h0000_0200);
            compare_model($sformatf("post_mis%0d", i));
            @(negedge clk);
        end

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1 compare_reset("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 600; i++) begin
            logic        s, rv;
            logic [31:0] rpc;
            s   = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            rpc = $urandom & ~32'h3;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hC);
            if ($urandom_range(0, 39) == 0) rpc = rpc | 32'($urandom_range(1, 3));
            step(s, rv, rpc);
            compare_model($sformatf("rand%0d", i));
            if (i % 150 == 149) begin
                #($urandom_range(1, 3)) rst_n = 1'b0;
                #1 compare_reset($sformatf("rand_reset%0d", i));
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
